// File: rtl/div_pkg.sv
// Shared types and defaults for the divider-reconstruction block.
package div_pkg;

    // Default quotient/divisor/remainder width
    localparam int unsigned DIV_W     = 8;
    // Default accumulator width for error statistics
    localparam int unsigned DIV_ACC_W = 32;

    // Saturation ceiling of the default-width accumulators
    localparam logic [DIV_ACC_W-1:0] ACC_SAT_MAX_DEF = '1;

    // Reconstruction FSM states
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

endpackage : div_pkg

// File: rtl/div_recon_absdiff.sv
// Combinational unsigned absolute difference |a - b|, never wraps.
module div_recon_absdiff #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o
);

    // Subtract the smaller operand from the larger one
    always_comb begin
        diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    end

endmodule : div_recon_absdiff

// File: rtl/div_array_reconstruct_seq.sv
// Rebuilds n = q*d + r from a divider result with a W-cycle shift-add
// multiplier, reports |n_ref - n| and keeps saturating error statistics.
module div_array_reconstruct_seq
    import div_pkg::*;
#(
    parameter int unsigned W     = DIV_W,
    parameter int unsigned ACC_W = DIV_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_q,
    input  logic [W-1:0]     in_d,
    input  logic [W-1:0]     in_r,
    input  logic [2*W-1:0]   in_n_ref,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_n,
    output logic [2*W-1:0]   out_err,
    input  logic             clr,
    output logic [ACC_W-1:0] err_sum,
    output logic [ACC_W-1:0] sample_cnt
);

    localparam int unsigned NW = 2 * W;
    localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;
    // Wide enough to hold err_sum + out_err without losing the carry
    localparam int unsigned SW = ((ACC_W > NW) ? ACC_W : NW) + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = '1;

    state_e           state_q;
    logic [W-1:0]     q_q;
    logic [W-1:0]     d_q;
    logic [NW-1:0]    nref_q;
    logic [NW-1:0]    acc_q;
    logic [KW-1:0]    k_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [NW-1:0]    out_n_q;
    logic [NW-1:0]    out_err_q;
    logic [ACC_W-1:0] err_sum_q;
    logic [ACC_W-1:0] sample_cnt_q;

    logic [NW-1:0]    add_term;
    logic [NW-1:0]    acc_d;
    logic [NW-1:0]    err_d;
    logic             last_bit;
    logic             done_hs;
    logic [SW-1:0]    sum_wide;
    logic [ACC_W-1:0] err_sum_d;
    logic [ACC_W-1:0] sample_cnt_d;

    // Partial product for the current quotient bit and the next accumulator value
    always_comb begin
        add_term = '0;
        if (q_q[k_q]) begin
            add_term = NW'(d_q) << k_q;
        end
        acc_d    = acc_q + add_term;
        last_bit = (k_q == KW'(W - 1));
        done_hs  = (state_q == S_DONE) && out_valid_q && out_ready;
    end

    // Error of the final accumulator value, registered on the last MUL cycle
    div_recon_absdiff #(
        .N (NW)
    ) u_absdiff (
        .a_i    (nref_q),
        .b_i    (acc_d),
        .diff_o (err_d)
    );

    // Saturating next values for the statistics accumulators
    always_comb begin
        sum_wide  = SW'(err_sum_q) + SW'(out_err_q);
        err_sum_d = (sum_wide > SW'(SAT_MAX)) ? SAT_MAX : sum_wide[ACC_W-1:0];
        sample_cnt_d = (sample_cnt_q == SAT_MAX) ? SAT_MAX : sample_cnt_q + ACC_W'(1);
    end

    // Control FSM, shift-add datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            d_q         <= '0;
            nref_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            out_err_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        q_q        <= in_q;
                        d_q        <= in_d;
                        nref_q     <= in_n_ref;
                        acc_q      <= NW'(in_r);
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + KW'(1);
                    if (last_bit) begin
                        out_valid_q <= 1'b1;
                        out_n_q     <= acc_d;
                        out_err_q   <= err_d;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Error statistics; clear takes priority over a coincident result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum_q    <= '0;
            sample_cnt_q <= '0;
        end else if (clr) begin
            err_sum_q    <= '0;
            sample_cnt_q <= '0;
        end else if (done_hs) begin
            err_sum_q    <= err_sum_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_n      = out_n_q;
    assign out_err    = out_err_q;
    assign err_sum    = err_sum_q;
    assign sample_cnt = sample_cnt_q;

endmodule : div_array_reconstruct_seq

// File: tb/tb_div_array_reconstruct_seq.sv
// Randomised self-checking bench for div_array_reconstruct_seq.
module tb_div_array_reconstruct_seq;

    localparam int unsigned W = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    in_q;
    logic [W-1:0]    in_d;
    logic [W-1:0]    in_r;
    logic [2*W-1:0]  in_n_ref;
    logic            out_ready;
    logic            clr;

    logic            in_ready;
    logic            out_valid;
    logic [2*W-1:0]  out_n;
    logic [2*W-1:0]  out_err;
    logic [31:0]     err_sum;
    logic [31:0]     sample_cnt;

    logic            s_in_ready;
    logic            s_out_valid;
    logic [2*W-1:0]  s_out_n;
    logic [2*W-1:0]  s_out_err;
    logic [3:0]      s_err_sum;
    logic [3:0]      s_sample_cnt;

    int checks = 0;
    int errors = 0;

    // Reference statistics: full-width and 4-bit saturating copies
    longint unsigned m_sum, m_cnt, m_sum4, m_cnt4;

    div_array_reconstruct_seq #(.W(W), .ACC_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_q       (in_q),
        .in_d       (in_d),
        .in_r       (in_r),
        .in_n_ref   (in_n_ref),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_n      (out_n),
        .out_err    (out_err),
        .clr        (clr),
        .err_sum    (err_sum),
        .sample_cnt (sample_cnt)
    );

    div_array_reconstruct_seq #(.W(W), .ACC_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_q       (in_q),
        .in_d       (in_d),
        .in_r       (in_r),
        .in_n_ref   (in_n_ref),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_n      (s_out_n),
        .out_err    (s_out_err),
        .clr        (clr),
        .err_sum    (s_err_sum),
        .sample_cnt (s_sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_err_sum"}, err_sum, m_sum);
        check({tag, "_sample_cnt"}, sample_cnt, m_cnt);
        check({tag, "_err_sum4"}, s_err_sum, m_sum4);
        check({tag, "_sample_cnt4"}, s_sample_cnt, m_cnt4);
    endtask

    function automatic longint unsigned sat_add(input longint unsigned a, input longint unsigned b,
                                                input longint unsigned lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    // One full transaction: feed a sample, check latency/result, stall, then consume
    task automatic send(input int unsigned q, input int unsigned d, input int unsigned r,
                        input int unsigned nref, input int unsigned stall, input bit do_clr);
        longint unsigned exp_n, exp_err;
        int unsigned wait_cnt, lat;
        exp_n   = longint'(q) * longint'(d) + longint'(r);
        exp_err = (nref >= exp_n) ? nref - exp_n : exp_n - nref;

        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        in_q     = W'(q);
        in_d     = W'(d);
        in_r     = W'(r);
        in_n_ref = (2*W)'(nref);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_q     = W'($urandom);
        in_d     = W'($urandom);
        in_r     = W'($urandom);
        in_n_ref = (2*W)'($urandom);

        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W + 1);
        check("out_n", out_n, exp_n);
        check("out_err", out_err, exp_err);
        check("out_n4", s_out_n, exp_n);
        check("in_ready_busy", in_ready, 0);

        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_out_n", out_n, exp_n);
            check("stall_out_err", out_err, exp_err);
            check("stall_in_ready", in_ready, 0);
            check_stats("stall");
        end

        out_ready = 1'b1;
        clr       = do_clr;
        @(negedge clk);
        out_ready = 1'b0;
        clr       = 1'b0;
        if (do_clr) begin
            m_sum = 0; m_cnt = 0; m_sum4 = 0; m_cnt4 = 0;
        end else begin
            m_sum  = sat_add(m_sum, exp_err, 64'hFFFF_FFFF);
            m_cnt  = sat_add(m_cnt, 1, 64'hFFFF_FFFF);
            m_sum4 = sat_add(m_sum4, exp_err, 15);
            m_cnt4 = sat_add(m_cnt4, 1, 15);
        end
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check_stats("post_hs");
    endtask

    initial begin
        int unsigned q, d, r, nref;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_q      = '0;
        in_d      = '0;
        in_r      = '0;
        in_n_ref  = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        m_sum = 0; m_cnt = 0; m_sum4 = 0; m_cnt4 = 0;

        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_n", out_n, 0);
        check("rst_out_err", out_err, 0);
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // Directed samples
        send(20, 49, 20, 1000, 0, 1'b1);
        send(20, 49, 5, 1000, 0, 1'b0);
        send(21, 49, 0, 1000, 0, 1'b0);
        check("approx_err_sum", err_sum, 44);
        check("approx_cnt", sample_cnt, 2);
        send(255, 255, 255, 65280, 0, 1'b0);
        send(123, 0, 7, 7, 1, 1'b0);
        send(0, 77, 9, 100, 0, 1'b0);
        send(37, 200, 199, 12345, 5, 1'b0);
        send(10, 10, 10, 500, 2, 1'b1);
        check("clr_hs_err_sum", err_sum, 0);
        check("clr_hs_cnt", sample_cnt, 0);

        // Random samples, mix of exact and erroneous reconstructions
        for (int i = 0; i < 40; i++) begin
            q = $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            r = $urandom_range(0, 255);
            nref = ($urandom_range(0, 1) == 0) ? q * d + r : $urandom_range(0, 65535);
            send(q, d, r, nref, $urandom_range(0, 2), $urandom_range(0, 19) == 0);
        end
        check("sat_cnt4", s_sample_cnt, m_cnt4);

        // Abort mid-multiply with reset
        @(negedge clk);
        in_q = 8'd3; in_d = 8'd4; in_r = 8'd1; in_n_ref = 16'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_sum = 0; m_cnt = 0; m_sum4 = 0; m_cnt4 = 0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check_stats("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rel_in_ready", in_ready, 1);
        check("abort_rel_valid", out_valid, 0);

        for (int i = 0; i < 20; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 65535), $urandom_range(0, 1), 1'b0);
        end
        check("final_cnt", sample_cnt, 20);
        check("final_cnt4", s_sample_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_array_reconstruct_seq
